// File: rtl/cpu_io_sequencer.sv
// Host-side driver for the CPU switch port: queues operand bytes, presents each on SW,
// strobes SW8 for HOLD cycles, then samples outport CAP_DELAY cycles after SW8 falls.
module cpu_io_sequencer #(
  parameter int n         = 8,
  parameter int DEPTH     = 4,
  parameter int HOLD      = 4,
  parameter int CAP_DELAY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [n-1:0]           in_data,
  output logic                   in_ready,
  output logic [n-1:0]           SW,
  output logic                   SW8,
  input  logic [n-1:0]           outport,
  output logic                   res_valid,
  output logic [n-1:0]           res_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (HOLD > CAP_DELAY) ? HOLD : CAP_DELAY;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD - 1);
  localparam logic [TW-1:0] CAP_LAST  = TW'(CAP_DELAY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ASSERT, ST_WAIT} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic [n-1:0]    sw_reg, res_data_reg;
  logic            sw8_reg, res_valid_reg;
  logic            push, pop, capture;
  logic [n-1:0]    fifo_mem [DEPTH];

  // in_ready looks at the pre-pop count, so a full FIFO refuses data in its pop cycle
  assign in_ready  = (count_reg < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign pop       = (state_reg == ST_LOAD);
  assign SW        = sw_reg;
  assign SW8       = sw8_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign count     = count_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (!push && pop)
      count_next = count_reg - 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (count_reg != '0)
          state_next = ST_LOAD;
      end
      ST_LOAD: begin
        state_next = ST_ASSERT;
        timer_next = '0;
      end
      ST_ASSERT: begin
        if (timer_reg == HOLD_LAST) begin
          state_next = ST_WAIT;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_WAIT: begin
        if (timer_reg == CAP_LAST) begin
          state_next = ST_IDLE;
          capture    = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Storage carries no reset; a flush only needs the pointers and count cleared
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      sw_reg        <= '0;
      sw8_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      count_reg     <= count_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        sw_reg     <= fifo_mem[rd_ptr_reg];
      end
      // Strobe is registered from the next state so it has no combinational path to the pin
      sw8_reg       <= (state_next == ST_ASSERT);
      res_valid_reg <= capture;
      if (capture)
        res_data_reg <= outport;
    end
  end

endmodule
